game_timer: RTL and testbench
=============================

# game_timer

Countdown timer for one game round, directly downstream of the game controller. It consumes the controller's `timerEn`, `timerReconfig` and `lettNum`, and returns the `timeOut` level the controller samples. It also drives two BCD seconds digits for the seven-segment display path. All state is clocked on `clk` with a synchronous, active-high `rst`.

## Interface
Parameters:
- `TICKS_PER_SEC`, default 50000000: `clk` cycles per game second. Legal range ≥ 2; benches use 4.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `timerEn`  input  1  level; count while high, hold while low.
- `timerReconfig`  input  1  one-cycle pulse; reload the round duration from `lettNum`.
- `lettNum`  input  2  round-length select, sampled only on `timerReconfig`.
- `timeOut`  output  1  level; high once the count has reached 00, cleared only by reload or `rst`.
- `secTens`  output  4  BCD tens digit of the remaining seconds.
- `secOnes`  output  4  BCD ones digit of the remaining seconds.
- `tickPls`  output  1  one-cycle pulse on every seconds decrement.

## Operation
- Reload table for `lettNum`:
  - 00 → 60 s
  - 01 → 45 s
  - 10 → 30 s
  - 11 → 20 s
- The remaining time is held directly as two BCD digits. No binary counter and no conversion.
- Prescaler:
  - Width is `$clog2(TICKS_PER_SEC)`.
  - Counts 0..`TICKS_PER_SEC`-1.
  - Advances only in RUN with `timerEn`=1; holds its value when `timerEn`=0 (pause, no loss of partial second).
- States:
  - READY: count loaded, prescaler 0, `timeOut`=0.
  - RUN: counting.
  - EXPIRED: count 00, `timeOut`=1.
- Transitions:
  - READY→RUN when `timerEn`=1. That same cycle counts as the first enabled cycle.
  - RUN→READY never occurs; with `timerEn`=0, RUN simply holds.
  - RUN→EXPIRED on the decrement that produces 00.
  - EXPIRED→READY only on `timerReconfig`.
  - Any state→READY on `timerReconfig`.
- Decrement, performed when the prescaler wraps from `TICKS_PER_SEC`-1 to 0:
  - If `secOnes`≠0: `secOnes`-1.
  - Else: `secOnes`=9 and `secTens`-1.
- In EXPIRED:
  - `timerEn` is ignored.
  - Digits stay 0/0.
  - The prescaler is held at 0.
  - `tickPls`=0.
- Priority, highest first:
  1. `rst`
  2. `timerReconfig`
  3. tick/decrement

## Timing
- Reset values (next edge with `rst`=1):
  - `secTens`=6, `secOnes`=0 (60 s)
  - prescaler=0
  - state READY
  - `timeOut`=0
  - `tickPls`=0
- All outputs are registered; there are no combinational input→output paths.
- `timerReconfig` on edge k:
  - Digits show the new value after edge k.
  - Prescaler=0 and `timeOut`=0 after edge k.
- With `timerEn` held high, the first decrement lands on the `TICKS_PER_SEC`-th enabled edge.
- `tickPls` is high for exactly the cycle following each decrement edge.
- Expiry:
  - `timeOut` rises on the same edge that the digits become 00, together with the final `tickPls`.
  - A full round takes duration×`TICKS_PER_SEC` enabled cycles.
- Boundary conditions:
  - `timerReconfig` on the same edge as the final decrement: the reload wins; `timeOut` stays 0 and `tickPls` stays 0.
  - `timerReconfig` and `timerEn` high together: reload only; counting starts on the next enabled edge.
  - `rst` mid-round: 60 s, READY, regardless of `lettNum`.
  - `timerEn` dropping on the wrap edge: the decrement on that edge still completes, because it was enabled during that cycle.

## Test plan
- Reset: `rst`=1 for 2 edges → `secTens`=6, `secOnes`=0, `timeOut`=0, `tickPls`=0; no change while `timerEn`=0 for 10 cycles.
- Load and first tick (`TICKS_PER_SEC`=4): pulse `timerReconfig` with `lettNum`=11 → 2/0. Then `timerEn`=1 → 1/9 after the 4th enabled edge, with `tickPls` high for exactly one cycle.
- BCD borrow and expiry: continue from 20 for 80 enabled cycles total.
  - Sequence must pass 20→19→…→10→09→…→00.
  - `timeOut` rises with 0/0 on edge 80.
  - 10 more enabled cycles: digits stay 0/0, `timeOut`=1, `tickPls`=0.
- Pause: reload 30. Enable 2 cycles, disable 5, enable 2 → decrement to 2/9 on the 4th enabled edge only; no decrement during the pause.
- Mid-run reload: at prescaler=2 with count 27, pulse `timerReconfig` with `lettNum`=01 → 4/5, then next decrement after 4 enabled edges. From EXPIRED, `timerReconfig` with `lettNum`=00 → 6/0 and `timeOut`=0.
- Collisions: `timerReconfig` on the final-decrement edge → reload value shown, `timeOut`=0. `rst` asserted mid-round with `lettNum`=10 → 6/0, READY.

Source files
------------

// File: rtl/game_timer.sv
// Round countdown timer: seconds held as two BCD digits, decremented by a
// prescaler that advances only on enabled cycles. timeOut latches at 00.
module game_timer #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       timerEn,
  input  logic       timerReconfig,
  input  logic [1:0] lettNum,
  output logic       timeOut,
  output logic [3:0] secTens,
  output logic [3:0] secOnes,
  output logic       tickPls,
  output logic [1:0] o_dbg_state
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] LP_LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    ST_READY   = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_nxt;
  logic [3:0]    r_tens;
  logic [3:0]    w_tens_nxt;
  logic [3:0]    r_ones;
  logic [3:0]    w_ones_nxt;
  logic          r_timeout;
  logic          w_timeout_nxt;
  logic          r_tick;
  logic          w_tick_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_READY;
      r_presc   <= '0;
      r_tens    <= 4'd6;
      r_ones    <= 4'd0;
      r_timeout <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_presc_nxt;
      r_tens    <= w_tens_nxt;
      r_ones    <= w_ones_nxt;
      r_timeout <= w_timeout_nxt;
      r_tick    <= w_tick_nxt;
    end
  end

  // Reload outranks counting; the READY->RUN cycle is itself an enabled cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_presc_nxt   = r_presc;
    w_tens_nxt    = r_tens;
    w_ones_nxt    = r_ones;
    w_timeout_nxt = r_timeout;
    w_tick_nxt    = 1'b0;
    if (timerReconfig) begin
      w_state_nxt   = ST_READY;
      w_presc_nxt   = '0;
      w_timeout_nxt = 1'b0;
      w_ones_nxt    = 4'd0;
      case (lettNum)
        2'b00:   w_tens_nxt = 4'd6;
        2'b01: begin
          w_tens_nxt = 4'd4;
          w_ones_nxt = 4'd5;
        end
        2'b10:   w_tens_nxt = 4'd3;
        default: w_tens_nxt = 4'd2;
      endcase
    end else if (timerEn && (r_state != ST_EXPIRED)) begin
      w_state_nxt = ST_RUN;
      if (r_presc == LP_LAST) begin
        w_presc_nxt = '0;
        w_tick_nxt  = 1'b1;
        if (r_ones != 4'd0) begin
          w_ones_nxt = r_ones - 4'd1;
        end else begin
          w_ones_nxt = 4'd9;
          w_tens_nxt = r_tens - 4'd1;
        end
        // 01 -> 00 is the final decrement of the round.
        if ((r_tens == 4'd0) && (r_ones == 4'd1)) begin
          w_state_nxt   = ST_EXPIRED;
          w_timeout_nxt = 1'b1;
        end
      end else begin
        w_presc_nxt = r_presc + PW'(1);
      end
    end
  end

  assign timeOut     = r_timeout;
  assign secTens     = r_tens;
  assign secOnes     = r_ones;
  assign tickPls     = r_tick;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_game_timer.sv
// Bench for game_timer: remaining-seconds model compared every cycle, plus
// scripted scenarios pinned with literal expectations and a random phase.
module tb_game_timer;

  localparam int TPS = 4;

  logic       clk;
  logic       rst;
  logic       timerEn;
  logic       timerReconfig;
  logic [1:0] lettNum;
  logic       timeOut;
  logic [3:0] secTens;
  logic [3:0] secOnes;
  logic       tickPls;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  // Behavioural model: remaining seconds as a plain integer.
  int m_secs    = 60;
  int m_phase   = 0;
  bit m_expired = 1'b0;
  bit m_tick    = 1'b0;

  game_timer #(.TICKS_PER_SEC(TPS)) dut (
    .clk          (clk),
    .rst          (rst),
    .timerEn      (timerEn),
    .timerReconfig(timerReconfig),
    .lettNum      (lettNum),
    .timeOut      (timeOut),
    .secTens      (secTens),
    .secOnes      (secOnes),
    .tickPls      (tickPls),
    .o_dbg_state  (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int reload_secs(input logic [1:0] sel);
    case (sel)
      2'b00:   return 60;
      2'b01:   return 45;
      2'b10:   return 30;
      default: return 20;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_secs = 60; m_phase = 0; m_expired = 1'b0; m_tick = 1'b0;
    end else if (timerReconfig) begin
      m_secs = reload_secs(lettNum); m_phase = 0; m_expired = 1'b0; m_tick = 1'b0;
    end else if (timerEn && !m_expired) begin
      m_phase = m_phase + 1;
      m_tick  = 1'b0;
      if (m_phase == TPS) begin
        m_phase = 0;
        m_secs  = m_secs - 1;
        m_tick  = 1'b1;
        if (m_secs == 0) m_expired = 1'b1;
      end
    end else begin
      m_tick = 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard compare on the inactive edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_tens", int'(secTens), m_secs / 10);
      chk("model_ones", int'(secOnes), m_secs % 10);
      chk("model_timeout", int'(timeOut), int'(m_expired));
      chk("model_tick", int'(tickPls), int'(m_tick));
    end
  end

  // Driver tasks: called at a negedge; apply inputs, return after the next negedge.
  task automatic step(input bit en, input bit rc, input logic [1:0] ln);
    timerEn = en; timerReconfig = rc; lettNum = ln;
    @(negedge clk);
    timerReconfig = 1'b0;
  endtask

  task automatic run_en(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'b00);
  endtask

  task automatic chk_digits(input string name, input int t, input int o, input int to);
    chk({name, "_tens"}, int'(secTens), t);
    chk({name, "_ones"}, int'(secOnes), o);
    chk({name, "_timeout"}, int'(timeOut), to);
  endtask

  initial begin
    rst = 1'b1; timerEn = 1'b0; timerReconfig = 1'b0; lettNum = 2'b00;
    @(negedge clk);
    step(1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b0, 2'b00);
    rst = 1'b0;
    cmp_on = 1'b1;
    chk_digits("reset", 6, 0, 0);
    chk("reset_tick", int'(tickPls), 0);
    chk("reset_state", int'(dbg_state), 0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 2'b00);
    chk_digits("idle", 6, 0, 0);

    // Load 20 s and first tick.
    step(1'b0, 1'b1, 2'b11);
    chk_digits("load20", 2, 0, 0);
    run_en(3);
    chk_digits("pre_tick", 2, 0, 0);
    chk("pre_tick_pls", int'(tickPls), 0);
    run_en(1);
    chk_digits("first_tick", 1, 9, 0);
    chk("first_tick_pls", int'(tickPls), 1);
    run_en(1);
    chk("tick_one_cycle", int'(tickPls), 0);
    run_en(74);
    chk_digits("edge79", 0, 1, 0);
    run_en(1);
    chk_digits("expire", 0, 0, 1);
    chk("expire_tick", int'(tickPls), 1);
    run_en(10);
    chk_digits("expired_hold", 0, 0, 1);
    chk("expired_tick", int'(tickPls), 0);

    // Pause keeps the partial second.
    step(1'b0, 1'b1, 2'b10);
    chk_digits("load30", 3, 0, 0);
    run_en(2);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 2'b00);
    run_en(1);
    chk_digits("pause_hold", 3, 0, 0);
    run_en(1);
    chk_digits("pause_tick", 2, 9, 0);

    // Mid-run reload with timerEn high: reload only.
    run_en(10);
    chk_digits("at27", 2, 7, 0);
    step(1'b1, 1'b1, 2'b01);
    chk_digits("reload45", 4, 5, 0);
    run_en(3);
    chk_digits("reload45_hold", 4, 5, 0);
    run_en(1);
    chk_digits("reload45_tick", 4, 4, 0);

    // Reload from EXPIRED.
    step(1'b0, 1'b1, 2'b11);
    run_en(80);
    chk_digits("expire2", 0, 0, 1);
    step(1'b0, 1'b1, 2'b00);
    chk_digits("from_expired", 6, 0, 0);

    // Reload collides with the final decrement.
    step(1'b0, 1'b1, 2'b11);
    run_en(79);
    step(1'b1, 1'b1, 2'b10);
    chk_digits("collide", 3, 0, 0);
    chk("collide_tick", int'(tickPls), 0);

    // Reset mid-round ignores lettNum.
    run_en(10);
    rst = 1'b1;
    step(1'b1, 1'b0, 2'b10);
    rst = 1'b0;
    chk_digits("mid_rst", 6, 0, 0);
    chk("mid_rst_state", int'(dbg_state), 0);

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0),
           2'($urandom_range(0, 3)));
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
